// File: rtl/shift_ctrl_pkg.sv
// Shared constants for the serial transmit sequencer.
// State encoding and default widths.
package shift_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] IDLE  = 3'd0;
  localparam logic [ST_W-1:0] LOAD  = 3'd1;
  localparam logic [ST_W-1:0] SHIFT = 3'd2;
  localparam logic [ST_W-1:0] PAR   = 3'd3;
  localparam logic [ST_W-1:0] DONE  = 3'd4;

endpackage

// File: rtl/shift_bit_cnt.sv
// Bit counter for the shift phase.
// Flags the final bit position (count == WIDTH-1).
module shift_bit_cnt
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_ser_ctrl.sv
// Parallel-to-serial sequencer driving a load/shift register.
// Optional parity bit via SHIFT_SER_PARITY_EN.
module shift_ser_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_I,
  output logic             sr_SI,
  input  logic             sr_SO,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic [WIDTH-1:0] sr_i_q;
  logic [WIDTH-1:0] sr_i_d;
  logic             last;
  logic             abort_act;
  logic             cnt_clr;
  logic             cnt_inc;

  // abort only matters while a word is in flight.
  assign abort_act = abort &&
    (state_q == LOAD || state_q == SHIFT ||
     state_q == PAR);

  assign cnt_clr = (state_q == LOAD) || abort_act;
  assign cnt_inc = (state_q == SHIFT) && !last;

  shift_bit_cnt #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .last(last)
  );

  // Next-state and word capture.
  always_comb begin
    state_d = state_q;
    sr_i_d  = sr_i_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_i_d  = in_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort)
          state_d = IDLE;
        else if (last)
`ifdef SHIFT_SER_PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
      end
`ifdef SHIFT_SER_PARITY_EN
      PAR: begin
        state_d = abort ? IDLE : DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_i_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_i_q  <= sr_i_d;
    end
  end

  // Moore output decode; ser_out follows SO in SHIFT.
  always_comb begin
    ser_out = 1'b0;
    if (state_q == SHIFT)
      ser_out = sr_SO;
`ifdef SHIFT_SER_PARITY_EN
    else if (state_q == PAR)
      ser_out = ^sr_i_q;
`endif
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sr_load   = (state_q == LOAD);
  assign sr_shift  = (state_q == SHIFT);
  assign ser_valid = (state_q == SHIFT) ||
                     (state_q == PAR);
  assign done      = (state_q == DONE);
  assign sr_I      = sr_i_q;
  assign sr_SI     = 1'b0;

endmodule
